// File: rtl/rx_pkg.sv
// Shared receive-chain defaults and the accumulator width helper used by the
// moving-mean filter.
package rx_pkg;

  localparam int DW_DEF    = 26;
  localparam int LOG2N_DEF = 10;
  localparam int NCH_DEF   = 2;

  // Running sum grows by LOG2N bits over an N-deep window.
  function automatic int SUMW(input int dw, input int log2n);
    return dw + log2n;
  endfunction

endpackage

// File: rtl/moving_mean_sample_delay.sv
// sample_delay: DEPTH-deep enable-gated sample delay line with synchronous clear.
// Shallow lines are a shift register; deep ones are a block-RAM circular buffer.
module sample_delay #(
  parameter int DW    = 26,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic w_wr;
  assign w_wr = en & ~clr;

  generate
    if (DEPTH >= 64) begin : g_ram
      localparam int AW = $clog2(DEPTH);

      logic [DW-1:0] r_mem [DEPTH];
      logic [DW-1:0] r_rd;
      logic [AW-1:0] r_ptr;
      logic [AW-1:0] w_rd_addr;
      logic          r_wrapped;

      // Prefetch the slot that will be oldest on the next cycle so the
      // registered RAM read lines up with the write pointer.
      always_comb begin
        w_rd_addr = r_ptr;
        if (clr)       w_rd_addr = '0;
        else if (w_wr) w_rd_addr = r_ptr + 1'b1;
      end

      always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_ptr] <= din;
        r_rd <= r_mem[w_rd_addr];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ptr     <= '0;
          r_wrapped <= 1'b0;
        end else if (clr) begin
          r_ptr     <= '0;
          r_wrapped <= 1'b0;
        end else if (w_wr) begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == AW'(DEPTH - 1)) r_wrapped <= 1'b1;
        end
      end

      // RAM contents cannot be cleared in one edge; slots not yet rewritten
      // since reset/clear read as zero instead.
      assign dout = r_wrapped ? r_rd : '0;
    end else begin : g_shift
      logic [DEPTH*DW-1:0] r_line;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_line <= '0;
        else if (clr)  r_line <= '0;
        else if (w_wr) r_line <= {r_line[(DEPTH-1)*DW-1:0], din};
      end

      assign dout = r_line[DEPTH*DW-1 -: DW];
    end
  endgenerate

endmodule

// File: rtl/moving_mean.sv
// moving_mean: per-channel N-sample running mean (N = 2**LOG2N) with a shared fill counter.
// Optional DC-removed output enabled by defining MOVING_MEAN_DCREMOVE_EN.
module moving_mean
  import rx_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int LOG2N = LOG2N_DEF,
  parameter int NCH   = NCH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              din_valid,
  input  logic [NCH*DW-1:0] din,
  output logic [NCH*DW-1:0] mean,
  output logic              mean_valid,
`ifdef MOVING_MEAN_DCREMOVE_EN
  output logic [NCH*DW-1:0] dout,
  output logic              dout_valid,
`endif
  output logic              full
);

  localparam int SW = SUMW(DW, LOG2N);
  localparam int N  = 1 << LOG2N;
  localparam logic [LOG2N:0] C_N = (LOG2N+1)'(N);

  logic [LOG2N:0] r_count;
  logic           r_mean_valid;
  logic           w_accept;

  assign w_accept   = din_valid & ~clr;
  assign full       = (r_count == C_N);
  assign mean_valid = r_mean_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_mean_valid <= 1'b0;
    end else if (clr) begin
      r_count      <= '0;
      r_mean_valid <= 1'b0;
    end else begin
      r_mean_valid <= din_valid && (r_count >= C_N - 1'b1);
      if (din_valid && (r_count != C_N)) r_count <= r_count + 1'b1;
    end
  end

`ifdef MOVING_MEAN_DCREMOVE_EN
  assign dout_valid = r_mean_valid;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic        [DW-1:0] w_in;
      logic        [DW-1:0] w_old;
      logic signed [SW-1:0] r_sum;
      logic signed [SW-1:0] w_sum_next;
      logic        [DW-1:0] r_mean;

      assign w_in = din[gi*DW +: DW];

      sample_delay #(
        .DW    (DW),
        .DEPTH (N)
      ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (w_accept),
        .din  (w_in),
        .dout (w_old)
      );

      assign w_sum_next = r_sum + {{LOG2N{w_in[DW-1]}}, w_in}
                                - {{LOG2N{w_old[DW-1]}}, w_old};

      // Dropping the low LOG2N bits of a two's-complement sum is a floor divide.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum  <= '0;
          r_mean <= '0;
        end else if (clr) begin
          r_sum  <= '0;
          r_mean <= '0;
        end else if (din_valid) begin
          r_sum  <= w_sum_next;
          r_mean <= w_sum_next[SW-1:LOG2N];
        end
      end

      assign mean[gi*DW +: DW] = r_mean;

`ifdef MOVING_MEAN_DCREMOVE_EN
      logic [DW:0]   w_diff;
      logic [DW-1:0] w_sat;
      logic [DW-1:0] r_dout;

      assign w_diff = {w_in[DW-1], w_in} - {r_mean[DW-1], r_mean};

      always_comb begin
        w_sat = w_diff[DW-1:0];
        if (w_diff[DW] != w_diff[DW-1])
          w_sat = w_diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_dout <= '0;
        else if (clr)       r_dout <= '0;
        else if (din_valid) r_dout <= w_sat;
      end

      assign dout[gi*DW +: DW] = r_dout;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_moving_mean.sv
// Directed bench for moving_mean with LOG2N=4, DW=26, NCH=2.
// Define MOVING_MEAN_DCREMOVE_EN to also exercise the DC-removed output.
module tb_moving_mean;

  localparam int DW    = 26;
  localparam int LOG2N = 4;
  localparam int NCH   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              din_valid = 1'b0;
  logic [NCH*DW-1:0] din = '0;
  logic [NCH*DW-1:0] mean;
  logic              mean_valid;
  logic              full;
`ifdef MOVING_MEAN_DCREMOVE_EN
  logic [NCH*DW-1:0] dout;
  logic              dout_valid;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  moving_mean #(.DW(DW), .LOG2N(LOG2N), .NCH(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .din_valid  (din_valid),
    .din        (din),
    .mean       (mean),
    .mean_valid (mean_valid),
`ifdef MOVING_MEAN_DCREMOVE_EN
    .dout       (dout),
    .dout_valid (dout_valid),
`endif
    .full       (full)
  );

  function automatic logic signed [63:0] sx(input logic [DW-1:0] v);
    return 64'($signed(v));
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_means(input string tag, input longint e0, input longint e1);
    chk({tag, "_m0"}, sx(mean[DW-1:0]), e0);
    chk({tag, "_m1"}, sx(mean[2*DW-1:DW]), e1);
  endtask

  // Present one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic v, input longint a, input longint b, input logic c);
    @(negedge clk);
    din_valid = v;
    clr       = c;
    din       = {b[DW-1:0], a[DW-1:0]};
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clr       = 1'b0;
    $display("step v=%0b clr=%0b din=%0d/%0d -> mean=%0d/%0d mv=%0b full=%0b",
             v, c, a, b, sx(mean[DW-1:0]), sx(mean[2*DW-1:DW]), mean_valid, full);
  endtask

  initial begin
    // Reset state
    #12;
    chk_means("reset", 0, 0);
    chk("reset_mv", 64'(mean_valid), 0);
    chk("reset_full", 64'(full), 0);
    @(negedge clk);
    rst = 1'b0;

    // Constant 1000 / -1000 fill ramp
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1000, -1000, 1'b0);
      chk_means("ramp", (k * 1000) >>> 4, (-k * 1000) >>> 4);
      chk("ramp_mv", 64'(mean_valid), (k == 16) ? 1 : 0);
      chk("ramp_full", 64'(full), (k == 16) ? 1 : 0);
    end
    cyc(1'b1, 1000, -1000, 1'b0);
    chk_means("steady", 1000, -1000);
    chk("steady_mv", 64'(mean_valid), 1);

    // Idle cycle holds mean and drops the strobe
    cyc(1'b0, 7777, 7777, 1'b0);
    chk_means("idle", 1000, -1000);
    chk("idle_mv", 64'(mean_valid), 0);
    chk("idle_full", 64'(full), 1);

    // clr wins over a simultaneous sample, which is discarded
    cyc(1'b1, 5000, 5000, 1'b1);
    chk_means("clr", 0, 0);
    chk("clr_full", 64'(full), 0);
    chk("clr_mv", 64'(mean_valid), 0);
    for (int k = 1; k <= 15; k++) cyc(1'b1, 1000, -1000, 1'b0);
    chk_means("refill15", 937, -938);
    chk("refill15_full", 64'(full), 0);
    cyc(1'b1, 1000, -1000, 1'b0);
    chk_means("refill16", 1000, -1000);
    chk("refill16_full", 64'(full), 1);
    chk("refill16_mv", 64'(mean_valid), 1);

    // Floor behaviour on negatives; channel 1 stays zero
    cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b1, -1, 0, 1'b0);
    chk_means("floor_m1", -1, 0);
    cyc(1'b1, -3, 0, 1'b0);
    chk_means("floor_m4", -1, 0);
    for (int k = 2; k <= 16; k++) cyc(1'b1, -3, 0, 1'b0);
    chk_means("neg_steady", -3, 0);
    chk("neg_steady_mv", 64'(mean_valid), 1);

    // Alternate-cycle valid
    cyc(1'b0, 0, 0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1, 1600, 160, 1'b0);
      chk_means("alt_valid", 100 * k, 10 * k);
      chk("alt_valid_mv", 64'(mean_valid), 0);
      cyc(1'b0, 9999, 9999, 1'b0);
      chk_means("alt_idle", 100 * k, 10 * k);
      chk("alt_idle_mv", 64'(mean_valid), 0);
    end

    // Asynchronous reset mid-window
    for (int k = 1; k <= 16; k++) cyc(1'b1, 1000, -1000, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_means("arst", 0, 0);
    chk("arst_full", 64'(full), 0);
    chk("arst_mv", 64'(mean_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1000, -1000, 1'b0);
    chk_means("post_rst", 62, -63);
    chk("post_rst_full", 64'(full), 0);
    chk("post_rst_mv", 64'(mean_valid), 0);

`ifdef MOVING_MEAN_DCREMOVE_EN
    // DC removal and saturation
    cyc(1'b0, 0, 0, 1'b1);
    for (int k = 1; k <= 16; k++) cyc(1'b1, 500, -(64'sd1 <<< 25), 1'b0);
    chk_means("dc_fill", 500, -(64'sd1 <<< 25));
    cyc(1'b1, 600, (64'sd1 <<< 25) - 1, 1'b0);
    chk("dc_dout0", sx(dout[DW-1:0]), 100);
    chk("dc_dout1_sat", sx(dout[2*DW-1:DW]), (64'sd1 <<< 25) - 1);
    chk("dc_dout_valid", 64'(dout_valid), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
